// File: rtl/avr_timer_if.sv
// CPU data-bus view of the AVR timer: address, strobes, write data in;
// combinational read data, select and the registered interrupt request out.
interface avr_timer_if;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;
    logic        irq;

    modport master (
        output addr, wen, ren, wdata,
        input  rdata, sel, irq
    );

    modport slave (
        input  addr, wen, ren, wdata,
        output rdata, sel, irq
    );
endinterface

// File: rtl/avr_timer.sv
// Memory-mapped AVR timer/counter: prescaled counter, compare match with optional
// clear-on-compare, sticky overflow/compare flags and a registered interrupt request.
module avr_timer #(
    parameter int          WIDTH = 16,
    parameter logic [15:0] BASE  = 16'h004A
) (
    input  logic        clk,
    input  logic        reset,
    avr_timer_if.slave  bus
);

    localparam bit WIDE = (WIDTH == 16);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_TCNT_L = 3'd1,
        REG_TCNT_H = 3'd2,
        REG_OCR_L  = 3'd3,
        REG_OCR_H  = 3'd4,
        REG_FLAGS  = 3'd5
    } reg_e;

    typedef struct packed {
        logic       ocie;
        logic       toie;
        logic       ctc;
        logic [2:0] cs;
    } ctrl_t;

    // ---------------------------------------------------------------- decode
    logic [15:0] offset;
    reg_e        reg_sel;
    logic        wr;
    logic        rd;

    // Unsigned wrap makes addresses below BASE land far above 5.
    assign offset  = bus.addr - BASE;
    assign bus.sel = (offset < 16'd6);
    assign reg_sel = reg_e'(offset[2:0]);
    assign wr      = bus.sel & bus.wen;
    assign rd      = bus.sel & bus.ren & ~bus.wen;

    logic wr_ctrl, wr_tcnt_l, wr_tcnt_h, wr_ocr_l, wr_ocr_h, wr_flags;
    logic rd_tcnt_l;

    assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
    assign wr_tcnt_l = wr && (reg_sel == REG_TCNT_L);
    assign wr_tcnt_h = wr && (reg_sel == REG_TCNT_H);
    assign wr_ocr_l  = wr && (reg_sel == REG_OCR_L);
    assign wr_ocr_h  = wr && (reg_sel == REG_OCR_H);
    assign wr_flags  = wr && (reg_sel == REG_FLAGS);
    assign rd_tcnt_l = rd && (reg_sel == REG_TCNT_L);

    // ---------------------------------------------------------------- state
    ctrl_t            ctrl;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] ocr;
    logic [7:0]       temp;
    logic [9:0]       presc;
    logic             tov;
    logic             ocf;
    logic             irq_q;

    // ---------------------------------------------------------------- prescaler
    logic [9:0] div_m1;
    logic       running;
    logic       tick;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_m1  = 10'd0;
        running = 1'b1;
        case (ctrl.cs)
            3'd1:    div_m1 = 10'd0;
            3'd2:    div_m1 = 10'd7;
            3'd3:    div_m1 = 10'd63;
            3'd4:    div_m1 = 10'd255;
            3'd5:    div_m1 = 10'd1023;
            default: running = 1'b0;
        endcase
    end

    assign tick = running && (presc == div_m1);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= 10'd0;
        end else if (wr_ctrl || tick) begin
            presc <= 10'd0;
        end else if (running) begin
            presc <= presc + 10'd1;
        end
    end

    // ---------------------------------------------------------------- counter
    logic             count_max;
    logic             match;
    logic             tov_set;
    logic             ocf_set;
    logic [WIDTH-1:0] count_next;

    assign count_max = (count == {WIDTH{1'b1}});
    assign match     = (count == ocr);

    // A CPU write to TCNT_L overrides the tick completely, flags included.
    assign tov_set = tick & count_max & ~wr_tcnt_l;
    assign ocf_set = tick & match & ~wr_tcnt_l;

    always_comb begin
        count_next = count;
        if (wr_tcnt_l) begin
            count_next = WIDTH'({temp, bus.wdata});
        end else if (tick) begin
            if (count_max || (match && ctrl.ctc)) begin
                count_next = '0;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // ---------------------------------------------------------------- registers
    logic [15:0] count_ext;
    logic [15:0] ocr_ext;

    assign count_ext = 16'(count);
    assign ocr_ext   = 16'(ocr);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
            ocr  <= {WIDTH{1'b1}};
            temp <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                ctrl <= bus.wdata[5:0];
            end
            if (wr_ocr_l) begin
                ocr <= WIDTH'({temp, bus.wdata});
            end
            // TEMP is shared by both 16-bit pairs; the narrow build never touches it.
            if (WIDE) begin
                if (wr_tcnt_h || wr_ocr_h) begin
                    temp <= bus.wdata;
                end else if (rd_tcnt_l) begin
                    temp <= count_ext[15:8];
                end
            end
        end
    end

    // Flags are write-1-to-clear; a hardware set in the same cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            tov   <= 1'b0;
            ocf   <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            tov   <= (tov & ~(wr_flags & bus.wdata[0])) | tov_set;
            ocf   <= (ocf & ~(wr_flags & bus.wdata[1])) | ocf_set;
            irq_q <= (tov & ctrl.toie) | (ocf & ctrl.ocie);
        end
    end

    assign bus.irq = irq_q;

    // ---------------------------------------------------------------- read mux
    always_comb begin
        bus.rdata = 8'h00;
        if (bus.sel) begin
            case (reg_sel)
                REG_CTRL:   bus.rdata = {2'b00, ctrl};
                REG_TCNT_L: bus.rdata = count_ext[7:0];
                REG_TCNT_H: bus.rdata = WIDE ? temp : 8'h00;
                REG_OCR_L:  bus.rdata = ocr_ext[7:0];
                REG_OCR_H:  bus.rdata = WIDE ? ocr_ext[15:8] : 8'h00;
                REG_FLAGS:  bus.rdata = {6'b000000, ocf, tov};
                default:    bus.rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_timer.sv
// Directed bench for avr_timer: a 16-bit and an 8-bit instance on separate buses,
// every expected value worked out by hand from the register map and tick timing.
module tb_avr_timer;

    localparam logic [15:0] BASE    = 16'h004A;
    localparam logic [15:0] A_CTRL  = BASE;
    localparam logic [15:0] A_TCNTL = BASE + 16'd1;
    localparam logic [15:0] A_TCNTH = BASE + 16'd2;
    localparam logic [15:0] A_OCRL  = BASE + 16'd3;
    localparam logic [15:0] A_OCRH  = BASE + 16'd4;
    localparam logic [15:0] A_FLAGS = BASE + 16'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [7:0]  wdata;
    logic        tgt8;

    always #5 clk = ~clk;

    avr_timer_if bus16 ();
    avr_timer_if bus8 ();

    assign bus16.addr  = addr;
    assign bus16.wdata = wdata;
    assign bus16.wen   = wen & ~tgt8;
    assign bus16.ren   = ren & ~tgt8;
    assign bus8.addr   = addr;
    assign bus8.wdata  = wdata;
    assign bus8.wen    = wen & tgt8;
    assign bus8.ren    = ren & tgt8;

    wire [7:0] rdata = tgt8 ? bus8.rdata : bus16.rdata;
    wire       sel   = tgt8 ? bus8.sel   : bus16.sel;
    wire       irq   = tgt8 ? bus8.irq   : bus16.irq;

    avr_timer #(.WIDTH(16), .BASE(BASE)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    avr_timer #(.WIDTH(8),  .BASE(BASE)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int   total = 0;
    int   bad   = 0;
    logic last_sel;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        #1;
        d        = rdata;
        last_sel = sel;
        @(posedge clk);
        #1;
        ren = 1'b0;
    endtask

    task automatic expect_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, 16'(d), 16'(exp));
    endtask

    task automatic expect_reset_state(input string pfx);
        expect_reg({pfx, "_ctrl"},  A_CTRL,  8'h00);
        expect_reg({pfx, "_tcntl"}, A_TCNTL, 8'h00);
        expect_reg({pfx, "_tcnth"}, A_TCNTH, 8'h00);
        expect_reg({pfx, "_ocrl"},  A_OCRL,  8'hFF);
        expect_reg({pfx, "_ocrh"},  A_OCRH,  8'hFF);
        expect_reg({pfx, "_flags"}, A_FLAGS, 8'h00);
        check({pfx, "_irq"}, 16'(irq), 16'd0);
    endtask

    initial begin
        logic [7:0] seq [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        reset = 1'b1;
        addr  = 16'h0000;
        wen   = 1'b0;
        ren   = 1'b0;
        wdata = 8'h00;
        tgt8  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and address decode
        expect_reset_state("rst");
        expect_reg("sel_in_rdata", A_CTRL, 8'h00);
        check("sel_in", 16'(last_sel), 16'd1);
        bus_write(BASE + 16'd8, 8'h01);
        bus_write(BASE - 16'd1, 8'h01);
        expect_reg("out_rdata", BASE + 16'd8, 8'h00);
        check("out_sel", 16'(last_sel), 16'd0);
        expect_reg("out_no_start", A_TCNTL, 8'h00);
        bus_write(A_CTRL, 8'hFF);
        expect_reg("ctrl_mask", A_CTRL, 8'h3F);

        // /1 count and latched high byte
        bus_write(A_CTRL, 8'h01);
        repeat (5) @(posedge clk);
        expect_reg("div1_five", A_TCNTL, 8'h05);
        repeat (300) @(posedge clk);
        expect_reg("latch_low", A_TCNTL, 8'h32);
        repeat (300) @(posedge clk);
        expect_reg("latch_high", A_TCNTH, 8'h01);
        expect_reg("live_low", A_TCNTL, 8'h60);

        // Overflow, TOV interrupt and W1C
        bus_write(A_CTRL, 8'h00);
        bus_write(A_TCNTH, 8'hFF);
        bus_write(A_TCNTL, 8'hFE);
        bus_write(A_CTRL, 8'h11);
        repeat (2) @(posedge clk);
        #1;
        check("irq_before", 16'(irq), 16'd0);
        expect_reg("wrap_low", A_TCNTL, 8'h00);
        check("irq_after", 16'(irq), 16'd1);
        expect_reg("wrap_flags", A_FLAGS, 8'h03);
        bus_write(A_FLAGS, 8'h01);
        check("irq_clr_lag", 16'(irq), 16'd1);
        @(posedge clk);
        #1;
        check("irq_clr", 16'(irq), 16'd0);
        expect_reg("tov_cleared", A_FLAGS, 8'h02);

        // CTC at /8 with OCR=3
        bus_write(A_CTRL, 8'h00);
        bus_write(A_FLAGS, 8'h03);
        bus_write(A_OCRH, 8'h00);
        bus_write(A_OCRL, 8'h03);
        bus_write(A_TCNTH, 8'h00);
        bus_write(A_TCNTL, 8'h00);
        expect_reg("ctc_flags0", A_FLAGS, 8'h00);
        expect_reg("ocr_l", A_OCRL, 8'h03);
        bus_write(A_CTRL, 8'h0A);
        repeat (7) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            expect_reg($sformatf("ctc_pre%0d", k),  A_TCNTL, seq[k]);
            expect_reg($sformatf("ctc_post%0d", k), A_TCNTL, seq[k+1]);
            repeat (6) @(posedge clk);
        end
        expect_reg("ctc_flags", A_FLAGS, 8'h02);

        // Flag set beats a same-cycle W1C
        bus_write(A_CTRL, 8'h00);
        bus_write(A_TCNTL, 8'h02);
        bus_write(A_CTRL, 8'h09);
        @(posedge clk);
        bus_write(A_FLAGS, 8'h02);
        expect_reg("set_wins", A_FLAGS, 8'h02);

        // TCNT_L write while ticking every cycle
        bus_write(A_TCNTH, 8'h12);
        bus_write(A_TCNTL, 8'h34);
        expect_reg("wr_vs_tick", A_TCNTL, 8'h34);
        expect_reg("wr_vs_tick_h", A_TCNTH, 8'h12);

        // Reset mid-count
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_reset_state("midrst");

        // Narrow instance
        tgt8 = 1'b1;
        bus_write(A_OCRH, 8'h55);
        expect_reg("w8_ocrh", A_OCRH, 8'h00);
        bus_write(A_TCNTH, 8'h77);
        expect_reg("w8_tcnth0", A_TCNTH, 8'h00);
        bus_write(A_OCRL, 8'h10);
        expect_reg("w8_ocrl", A_OCRL, 8'h10);
        bus_write(A_CTRL, 8'h01);
        repeat (16) @(posedge clk);
        expect_reg("w8_ocf_pre", A_FLAGS, 8'h00);
        expect_reg("w8_ocf", A_FLAGS, 8'h02);
        expect_reg("w8_tcnth", A_TCNTH, 8'h00);
        repeat (236) @(posedge clk);
        expect_reg("w8_tov_pre", A_FLAGS, 8'h02);
        expect_reg("w8_tov", A_FLAGS, 8'h03);
        expect_reg("w8_after_wrap", A_TCNTL, 8'h01);
        check("w8_irq", 16'(irq), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avr_timer.md
Name: avr_timer

Overview:
- Memory-mapped timer/counter peripheral for the AVR CPU data bus.
- Replaces the bare free-running IO counter with:
  - parametrised counter width
  - programmable prescaler
  - compare match with optional clear-on-compare (CTC)
  - sticky overflow/compare flags
  - interrupt request output
- Sits in the IO region below 0x0060; the top level muxes its combinational read data onto the CPU data_read path when it is selected.

Parameters:
- WIDTH, 16, counter width in bits; legal values 8 or 16.
- BASE, 16'h004A, data-space address of register offset 0; occupies BASE..BASE+5.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  16  CPU data address
- wen  input  1  data write strobe; write takes effect on the rising clk edge
- ren  input  1  data read strobe; side effects take effect on the rising clk edge
- wdata  input  8  CPU write data
- rdata  output  8  combinational read data for addr; 0 when not selected
- sel  output  1  combinational: addr is within BASE..BASE+5
- irq  output  1  registered interrupt request

Behaviour:
- Register map (offset from BASE):
  - 0 CTRL: [2:0] CS, [3] CTC, [4] TOIE, [5] OCIE, [7:6] read 0
  - 1 TCNT_L
  - 2 TCNT_H
  - 3 OCR_L
  - 4 OCR_H
  - 5 FLAGS: [0] TOV, [1] OCF, others read 0
- Reset values: count=0, OCR=all ones, CTRL=0, FLAGS=0, TEMP=0, prescaler=0, irq=0.
- Prescaler select (CS):
  - 0 = stopped
  - 1 = /1, 2 = /8, 3 = /64, 4 = /256, 5 = /1024
  - 6 and 7 = stopped
- Prescaler:
  - 10-bit counter runs while CS selects a divider.
  - "tick" is asserted in the cycle where prescaler == div-1; prescaler returns to 0 on that cycle.
  - With /1, tick is asserted every cycle.
  - Any write to CTRL clears the prescaler.
- Counting, evaluated on tick:
  - Compare match when count == OCR: OCF <= 1; in CTC mode count <= 0.
  - Otherwise, when count == 2^WIDTH-1: count <= 0 and TOV <= 1.
  - Otherwise count <= count+1.
  - CTC with OCR = max: both OCF and TOV are set and count wraps to 0.
- 16-bit atomic access (WIDTH=16), via one shared 8-bit TEMP register:
  - Read TCNT_L: rdata = count[7:0]; at the clock edge TEMP <= count[15:8]. Read TCNT_H returns TEMP.
  - Write TCNT_H or OCR_H: TEMP <= wdata.
  - Write TCNT_L: count <= {TEMP, wdata}.
  - Write OCR_L: OCR <= {TEMP, wdata}.
  - Read OCR_L/OCR_H: return OCR directly.
- WIDTH=8:
  - TCNT_H and OCR_H read 0; writes to them are ignored.
  - TEMP is unused.
  - TCNT_L and OCR_L access the registers directly.
- Simultaneous events:
  - CPU write to TCNT_L in a tick cycle: the written value wins; no increment and no flag set from that tick.
  - FLAGS is write-1-to-clear. If a flag set and a W1C clear of the same bit happen in one cycle, the set wins.
  - wen and ren together are not generated by the CPU; if both occur, wen takes priority for side effects.
- irq <= (TOV & TOIE) | (OCF & OCIE), registered: one cycle after the flag or enable changes.
- Reset mid-count returns every register to its reset value on the next edge.
- Accesses outside BASE..BASE+5 have no effect; rdata=0, sel=0.

Test Plan:
- Reset, then read all six offsets -> CTRL=00, TCNT=0000, OCR=FFFF, FLAGS=00; irq=0.
- CS=1, count from 0 -> TCNT_L reads 0x05 five cycles after the CTRL write. Read TCNT_L, then TCNT_H after 300 cycles -> high byte matches the value latched at the TCNT_L read, not the live count.
- Write TCNT_H=0xFF, TCNT_L=0xFE, CS=1, TOIE=1 -> count wraps to 0000 after 2 ticks; TOV=1; irq=1 on the following cycle. Write FLAGS=0x01 -> TOV=0, irq=0 one cycle later.
- OCR=0x0003, CTC=1, CS=2 (/8) -> count sequence 0,1,2,3,0 with each step 8 cycles apart; OCF set at the 3->0 transition; TOV stays 0.
- CS=1 and W1C of a pending OCF in the cycle a new match occurs -> OCF remains 1. TCNT_L write coincident with a tick -> count equals the written value.
- WIDTH=8 instance: OCR_L=0x10, CS=1 -> OCF after 17 cycles; TCNT_H reads 00; wrap at FF sets TOV.
